// File: rtl/pipeline_isa_pkg.sv
// ISA definitions shared by the issue controller and the Pipeline decoder.
package pipeline_isa_pkg;

    localparam logic [5:0] OP_MOV  = 6'd0;
    localparam logic [5:0] OP_NOT  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_ADD  = 6'd3;
    localparam logic [5:0] OP_NOR  = 6'd4;
    localparam logic [5:0] OP_NAND = 6'd5;
    localparam logic [5:0] OP_SUB  = 6'd6;
    localparam logic [5:0] OP_SLT  = 6'd7;
    localparam logic [5:0] OP_ADDI = 6'd11;
    localparam logic [5:0] OP_SUBI = 6'd14;

    localparam int OP_LSB = 26;
    localparam int RD_LSB = 21;
    localparam int RS_LSB = 16;
    localparam int RT_LSB = 11;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STALL
    } issue_state_t;

    typedef struct packed {
        logic       vld;
        logic [4:0] rd;
    } sb_entry_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_MOV, OP_NOT, OP_AND, OP_ADD, OP_NOR,
            OP_NAND, OP_SUB, OP_SLT, OP_ADDI, OP_SUBI: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        case (op)
            OP_AND, OP_ADD, OP_NOR, OP_NAND, OP_SUB, OP_SLT: return 1'b1;
            default:                                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction queue: DEPTH x 32 FIFO with occupancy count and synchronous flush.
module issue_fifo
    import pipeline_isa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                wdata,
    output logic [31:0]                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? NOP_INSTR : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue sequencer: queues instructions, holds RAW-dependent heads, feeds Pipeline.InstrIn.
//   state    | meaning
//   ST_IDLE  | queue empty, bubbles issued
//   ST_ISSUE | head issuing (or dropped as illegal)
//   ST_STALL | head held on a RAW hazard
module pipeline_issue_ctrl
    import pipeline_isa_pkg::*;
#(
    parameter int QDEPTH   = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic                      flush,
    output logic [31:0]               issue_instr,
    output logic                      issue_valid,
    output logic                      stall,
    output logic                      illegal,
    output logic [$clog2(QDEPTH):0]   occupancy
);
    localparam int CW = $clog2(QDEPTH) + 1;
    // A result is readable by an issue landing PIPE_LAT cycles later, so only the
    // newest PIPE_LAT-1 issued words (slot 0 = word on issue_instr) can block a decision.
    localparam int SB_N = PIPE_LAT - 1;

    sb_entry_t    sb [SB_N];
    issue_state_t state, state_next;

    logic [31:0] head;
    logic        q_empty, q_full;
    logic [5:0]  op;
    logic [4:0]  rd, rs, rt;
    logic        legal, haz, go, hold, pop, push_ok, will_empty;

    issue_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .flush (flush),
        .wdata (in_instr),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (occupancy)
    );

    assign in_ready = !q_full;

    always_comb begin
        op    = head[OP_LSB +: 6];
        rd    = head[RD_LSB +: 5];
        rs    = head[RS_LSB +: 5];
        rt    = head[RT_LSB +: 5];
        legal = is_legal(op);
        haz   = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (sb[i].vld && (sb[i].rd == rs || (uses_rt(op) && sb[i].rd == rt))) haz = 1'b1;
        end
        go         = !q_empty && legal && !haz;
        hold       = !q_empty && legal && haz;
        pop        = !q_empty && !hold;
        push_ok    = in_valid && !q_full && !flush;
        will_empty = flush || (occupancy == CW'(pop) && !push_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_instr <= NOP_INSTR;
            issue_valid <= 1'b0;
            stall       <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            issue_instr <= go ? head : NOP_INSTR;
            issue_valid <= go;
            stall       <= hold;
            illegal     <= !q_empty && !legal;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SB_N; i++) sb[i] <= '0;
        end else begin
            sb[0].vld <= go;
            sb[0].rd  <= rd;
            for (int i = 1; i < SB_N; i++) sb[i] <= sb[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (!will_empty) state_next = ST_ISSUE;
            ST_ISSUE: if (will_empty) state_next = ST_IDLE;
                      else if (hold) state_next = ST_STALL;
            ST_STALL: if (will_empty) state_next = ST_IDLE;
                      else if (!hold) state_next = ST_ISSUE;
            default:  state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Directed + random bench for pipeline_issue_ctrl against a queue/ready-time model.
module tb_pipeline_issue_ctrl;
    localparam int QDEPTH   = 4;
    localparam int PIPE_LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic        in_ready;
    logic [31:0] issue_instr;
    logic        issue_valid, stall, illegal;
    logic [2:0]  occupancy;

    pipeline_issue_ctrl #(.QDEPTH(QDEPTH), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .issue_instr(issue_instr),
        .issue_valid(issue_valid), .stall(stall), .illegal(illegal),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          ready_at [32];
    logic [31:0] mq [$];
    logic [31:0] log_instr [$];
    int          log_cyc [$];
    int          ill_cyc = -1;
    bit          saw_full = 0;
    int          ops [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 11, 14, 8, 63};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit legal_op(input int op);
        return (op <= 7) || (op == 11) || (op == 14);
    endfunction

    function automatic bit two_src(input int op);
        return (op >= 2) && (op <= 7);
    endfunction

    function automatic int when_issued(input logic [31:0] w);
        int r = -1;
        foreach (log_instr[i]) if (log_instr[i] == w) r = log_cyc[i];
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (ready_at[i]) ready_at[i] = 0;
    endtask

    // ready_at[r]: first visible issue cycle allowed to read r
    task automatic tick();
        int          sz;
        int          op;
        logic [31:0] h;
        bit          haz;
        logic [31:0] e_instr = 32'h0;
        logic        e_valid = 0, e_stall = 0, e_ill = 0;
        sz = mq.size();
        if (sz > 0) begin
            h  = mq[0];
            op = int'(h[31:26]);
            if (!legal_op(op)) begin
                void'(mq.pop_front());
                e_ill = 1;
            end else begin
                haz = (ready_at[h[20:16]] > cyc + 1) ||
                      (two_src(op) && ready_at[h[15:11]] > cyc + 1);
                if (haz) e_stall = 1;
                else begin
                    void'(mq.pop_front());
                    e_instr = h;
                    e_valid = 1;
                    ready_at[h[25:21]] = cyc + 1 + PIPE_LAT;
                end
            end
        end
        if (flush) mq.delete();
        else if (in_valid && sz < QDEPTH) mq.push_back(in_instr);
        @(posedge clk);
        #1;
        cyc++;
        chk("issue_instr", issue_instr, e_instr);
        chk("issue_valid", issue_valid, e_valid);
        chk("stall", stall, e_stall);
        chk("illegal", illegal, e_ill);
        chk("occupancy", occupancy, mq.size());
        chk("in_ready", in_ready, mq.size() < QDEPTH);
        if (issue_valid) begin
            log_instr.push_back(issue_instr);
            log_cyc.push_back(cyc);
        end
        if (illegal) ill_cyc = cyc;
        if (!in_ready) saw_full = 1;
    endtask

    task automatic push(input logic [31:0] w);
        bit acc = 0;
        int n = 0;
        in_valid = 1;
        in_instr = w;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 40);
        chk("push_accept", acc, 1);
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #12;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_instr", issue_instr, 32'h0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_illegal", illegal, 0);
        rst = 1;
        idle(2);

        // independent pair
        log_instr.delete(); log_cyc.delete();
        push(32'h0C61_1000);
        push(32'h08A2_1000);
        idle(5);
        chk("indep_gap", when_issued(32'h08A2_1000) - when_issued(32'h0C61_1000), 1);

        // RAW pair
        log_instr.delete(); log_cyc.delete();
        push(32'h0C61_1000);
        push(32'h0C83_1800);
        idle(6);
        chk("raw_gap", when_issued(32'h0C83_1800) - when_issued(32'h0C61_1000), PIPE_LAT);

        // immediate bits must not look like rt
        log_instr.delete(); log_cyc.delete();
        push(32'h0801_0800);
        push(32'h2C82_0014);
        idle(5);
        chk("imm_gap", when_issued(32'h2C82_0014) - when_issued(32'h0801_0800), 1);

        // backpressure with a dependent chain, then flush
        saw_full = 0;
        repeat (7) push(32'h0C63_1800);
        chk("backpressure_seen", saw_full, 1);
        in_valid = 1;
        in_instr = 32'h0C61_1000;
        flush    = 1;
        tick();
        flush    = 0;
        in_valid = 0;
        chk("flush_occupancy", occupancy, 0);
        log_instr.delete(); log_cyc.delete();
        idle(6);
        chk("flush_no_issue", log_instr.size(), 0);

        // illegal head dropped, next instruction follows
        log_instr.delete(); log_cyc.delete();
        ill_cyc = -1;
        push(32'h2000_0000);
        push(32'h0C61_1000);
        idle(4);
        chk("illegal_then_add", when_issued(32'h0C61_1000) - ill_cyc, 1);

        // reset mid-stream with entries queued
        push(32'h0C63_1800);
        push(32'h0C63_1800);
        push(32'h0C63_1800);
        push(32'h0C63_1800);
        rst = 0;
        #2;
        chk("midrst_issue_valid", issue_valid, 0);
        chk("midrst_issue_instr", issue_instr, 32'h0);
        chk("midrst_occupancy", occupancy, 0);
        chk("midrst_in_ready", in_ready, 1);
        model_reset();
        #2;
        rst = 1;
        log_instr.delete(); log_cyc.delete();
        idle(5);
        chk("midrst_no_issue", log_instr.size(), 0);

        // random traffic with a small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_instr = {6'(ops[$urandom_range(0, 11)]), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        11'($urandom_range(0, 2047))};
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        in_valid = 0;
        flush    = 0;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
